// File: rtl/io_bus_pkg.sv
// Shared types and constants for the RRIOT port-register bus initiator.
package io_bus_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_SET   = 2'd2,
        OP_CLR   = 2'd3
    } cmd_op_e;

    localparam logic [2:0] REG_PA       = 3'd0;
    localparam logic [2:0] REG_DDRA     = 3'd1;
    localparam logic [2:0] REG_PB       = 3'd2;
    localparam logic [2:0] REG_DDRB     = 3'd3;
    localparam logic [2:0] IO_IDLE_ADDR = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_STB  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_STB  = 3'd3,
        ST_RSP     = 3'd4
    } state_e;

    // Value written back by a bit-set / bit-clear read-modify-write.
    function automatic logic [7:0] rmw_value(input cmd_op_e op, input logic [7:0] rd,
                                             input logic [7:0] mask);
        logic [7:0] val;
        case (op)
            OP_SET:  val = rd | mask;
            OP_CLR:  val = rd & ~mask;
            default: val = rd;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/io_bus_master.sv
// Single-command initiator for the RRIOT port-register bus with read-modify-write support.
// Optional build macro IO_BUS_MASTER_POSTED_WR_EN: plain WRITEs complete without a response.
import io_bus_pkg::*;

module io_bus_master #(
    parameter int         READ_LAT  = 1,
    parameter logic [2:0] IDLE_ADDR = IO_IDLE_ADDR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       bus_we_n,
    output logic [2:0] bus_a,
    output logic [7:0] bus_di,
    input  logic [7:0] bus_do,
    input  logic       bus_oe
);

    state_e     state_r, state_s;
    cmd_op_e    op_r, op_s;
    logic [2:0] addr_r, addr_s;
    logic [7:0] data_r, data_s;
    logic [2:0] cnt_r, cnt_s;
    logic       bus_we_n_r, bus_we_n_s;
    logic [2:0] bus_a_r, bus_a_s;
    logic [7:0] bus_di_r, bus_di_s;
    logic       rsp_valid_r, rsp_valid_s;
    logic [7:0] rsp_data_r, rsp_data_s;
    logic       rsp_err_r, rsp_err_s;

    assign cmd_ready = (state_r == ST_IDLE);
    assign bus_we_n  = bus_we_n_r;
    assign bus_a     = bus_a_r;
    assign bus_di    = bus_di_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;

    // Next-state, bus strobe and response logic; the bus parks unless a strobe is scheduled.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        addr_s      = addr_r;
        data_s      = data_r;
        cnt_s       = cnt_r;
        bus_we_n_s  = 1'b1;
        bus_a_s     = IDLE_ADDR;
        bus_di_s    = bus_di_r;
        rsp_valid_s = rsp_valid_r;
        rsp_data_s  = rsp_data_r;
        rsp_err_s   = rsp_err_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_s       = cmd_op_e'(cmd_op);
                    addr_s     = cmd_addr;
                    data_s     = cmd_data;
                    rsp_data_s = 8'h00;
                    rsp_err_s  = 1'b0;
                    if (cmd_addr[2]) begin
                        state_s     = ST_RSP;
                        rsp_err_s   = 1'b1;
                        rsp_valid_s = 1'b1;
                    end else if (cmd_op_e'(cmd_op) == OP_WRITE) begin
                        state_s    = ST_WR_STB;
                        bus_we_n_s = 1'b0;
                        bus_a_s    = cmd_addr;
                        bus_di_s   = cmd_data;
                    end else begin
                        state_s = ST_RD_STB;
                        bus_a_s = cmd_addr;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_STB: begin
                state_s = ST_RD_WAIT;
                cnt_s   = 3'(READ_LAT);
            end
            ST_RD_WAIT: begin
                // Sample DO on the edge where the latency counter runs out.
                if (cnt_r == 3'd1) begin
                    cnt_s = 3'd0;
                    if (!bus_oe) begin
                        state_s     = ST_RSP;
                        rsp_err_s   = 1'b1;
                        rsp_data_s  = 8'h00;
                        rsp_valid_s = 1'b1;
                    end else begin
                        rsp_data_s = bus_do;
                        if (op_r == OP_READ) begin
                            state_s     = ST_RSP;
                            rsp_valid_s = 1'b1;
                        end else begin
                            state_s    = ST_WR_STB;
                            bus_we_n_s = 1'b0;
                            bus_a_s    = addr_r;
                            bus_di_s   = rmw_value(op_r, bus_do, data_r);
                        end
                    end
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            ST_WR_STB: begin
`ifdef IO_BUS_MASTER_POSTED_WR_EN
                if (op_r == OP_WRITE) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s     = ST_RSP;
                    rsp_valid_s = 1'b1;
                end
`else
                state_s     = ST_RSP;
                rsp_valid_s = 1'b1;
`endif
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_s     = ST_IDLE;
                    rsp_valid_s = 1'b0;
                end else begin
                    state_s = ST_RSP;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // State, command capture and registered bus/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_READ;
            addr_r      <= 3'd0;
            data_r      <= 8'h00;
            cnt_r       <= 3'd0;
            bus_we_n_r  <= 1'b1;
            bus_a_r     <= IDLE_ADDR;
            bus_di_r    <= 8'h00;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'h00;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            addr_r      <= addr_s;
            data_r      <= data_s;
            cnt_r       <= cnt_s;
            bus_we_n_r  <= bus_we_n_s;
            bus_a_r     <= bus_a_s;
            bus_di_r    <= bus_di_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_data_r  <= rsp_data_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
- Initiator for the RRIOT port-register bus (we_n / A[2:0] / DI / DO / OE).
- Accepts single register commands over a valid/ready channel and sequences the bus strobe. For reads, it waits for and captures DO.
- Supports atomic bit-set and bit-clear as read-modify-write (RMW).
- Returns data and status over a valid/ready response channel. Sits between the CPU-side fabric and the io block.

Parameters:
READ_LAT, 1, cycles after the read strobe cycle before DO is sampled (legal 1..7)
IDLE_ADDR, 3'b111, bus address driven while parked; must decode to no access

Ports:
clk  in  1  system clock
rst_n  in  1  reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  0 READ, 1 WRITE, 2 SET_BITS, 3 CLR_BITS
cmd_addr  in  3  register: 0 PA, 1 DDRA, 2 PB, 3 DDRB
cmd_data  in  8  write data / bit mask
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_data  out  8  read data (READ, SET/CLR: value read before modify), else 0
rsp_err  out  1  error status
bus_we_n  out  1  to io we_n
bus_a  out  3  to io A
bus_di  out  8  to io DI
bus_do  in  8  from io DO
bus_oe  in  1  from io OE

Behaviour:
- Reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
  - Reset values: bus_we_n=1, bus_a=IDLE_ADDR, bus_di=0, rsp_valid=0, rsp_data=0, rsp_err=0, state=IDLE.
- Bus outputs are registered.
  - Parked (bus_we_n=1, bus_a=IDLE_ADDR) in every cycle that is not a strobe cycle.
  - A strobe lasts exactly one cycle.
- States: IDLE, RD_STB, RD_WAIT, WR_STB, RSP.
- cmd_ready = (state==IDLE). It is combinational from state and does not depend on cmd_valid.
- Accept in IDLE (cycle 0):
  - cmd_addr[2]=1 → RSP with rsp_err=1, rsp_data=0. No bus strobe.
  - WRITE → WR_STB. During that cycle: bus_we_n=0, bus_a=addr, bus_di=data.
  - READ/SET/CLR → RD_STB. During that cycle: bus_we_n=1, bus_a=addr.
- RD_STB → RD_WAIT.
  - Counter loads READ_LAT.
  - bus_do/bus_oe are sampled on the edge at which the counter reaches 0. With READ_LAT=1 that is the edge ending cycle 2.
- Sample result:
  - bus_oe=0 → RSP with rsp_err=1, rsp_data=0. No write for RMW.
  - Otherwise the captured value goes to rsp_data.
  - READ → RSP.
  - SET → WR_STB with bus_di = rd | mask.
  - CLR → WR_STB with bus_di = rd & ~mask.
- WR_STB → RSP. rsp_err=0.
- RSP:
  - rsp_valid=1; rsp_data/rsp_err are held stable until rsp_ready.
  - On handshake → IDLE. cmd_ready rises the cycle after.
- Latency, accept edge to rsp_valid, READ_LAT=1:
  - WRITE: 2 cycles.
  - READ: 3 cycles.
  - SET/CLR: 4 cycles.
  - Bad address: 1 cycle.
- RMW semantics: the PA/PB read returns the pin-resolved value. The modify uses that value, not the output latch. This is intended.
- Back-to-back commands: a new command is accepted only in IDLE, so at least 1 idle cycle separates a response handshake from the next strobe.
- Reset mid-operation: the bus parks immediately (async). A pending RMW write is never issued. A pending response is discarded.
- cmd_* are sampled only at accept. Changes afterwards are ignored.

Optional Feature:
- Macro IO_BUS_MASTER_POSTED_WR_EN.
- Defined: WRITE returns WR_STB → IDLE directly with no response. cmd_ready is high again the cycle after the strobe. READ, SET, CLR and bad-address commands are unchanged.
- Undefined: every command produces exactly one response.

Decomposition:
- Package io_bus_pkg holds:
  - the cmd_op enum (OP_READ, OP_WRITE, OP_SET, OP_CLR);
  - register address constants (REG_PA=0, REG_DDRA=1, REG_PB=2, REG_DDRB=3);
  - IO_IDLE_ADDR=3'b111;
  - the state enum.
- No sub-module; single FSM with datapath.

Test Plan:
- Reset, then WRITE addr1 data 8'hF0 → one cycle with bus_we_n=0, bus_a=1, bus_di=F0. rsp_valid 2 cycles after accept, rsp_err=0. io DDRA=F0.
- DDRA=F0, PAO=A5, pins PAI=3C; READ addr0 → rsp_data=A C (8'hAC), rsp_err=0 at 3 cycles.
- PB: DDRB=FF, PBO=0x11; SET_BITS addr2 mask 0x80 → write strobe bus_di=0x91, rsp_data=0x11. Then CLR_BITS mask 0x01 → bus_di=0x90.
- READ addr 5 → no strobe (bus stays parked), rsp_err=1, rsp_data=0 one cycle after accept. READ with bus_oe forced 0 → rsp_err=1. SET with bus_oe=0 → no write strobe.
- Hold rsp_ready=0 for 5 cycles → rsp_valid/rsp_data stable, cmd_ready=0. Assert rst_n=0 during RD_WAIT of a SET → bus parks, no write, rsp_valid=0.
- With IO_BUS_MASTER_POSTED_WR_EN: 3 back-to-back WRITEs → no rsp_valid, strobes 2 cycles apart.
